led7_frame_decoder: RTL and testbench
=====================================

# led7_frame_decoder

Inverse of the hex-to-seven-segment encoding used on the TM1638 display path. The block accepts a stream of segment bytes, one per display digit, over a valid/ready handshake and decodes each byte back to a hex nibble. It assembles one full display frame into a packed hex value with per-digit decimal-point and error masks, and presents the frame on an output valid/ready handshake. It sits between a TM1638 display-RAM capture/loopback path and the self-check and readback logic.

## Interface
- `DIGITS`, default 8: digits per frame, range 1..16.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `seg_data` in 8: segment byte; bit 7 = DP, bits 6:0 = segments g..a.
- `seg_first` in 1: qualifies `seg_data` as digit 0 (most significant) of a frame.
- `seg_valid` in 1: input byte valid.
- `seg_ready` out 1: block can accept a byte (registered).
- `hex_value` out 4*DIGITS: decoded frame; digit 0 in bits [4*DIGITS-1 -: 4].
- `dp_mask` out DIGITS: DP per digit; digit 0 in bit DIGITS-1.
- `bad_mask` out DIGITS: 1 = segment pattern not a valid hex glyph; digit 0 in bit DIGITS-1.
- `out_valid` out 1: frame outputs valid.
- `out_ready` in 1: consumer accepts the frame.

## Operation
- Decode bits 6:0 against these 16 patterns (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Any other 7-bit value, including blank 00, decodes to nibble 0 and sets the digit's `bad_mask` bit. Bit 7 goes to `dp_mask` unchanged for every digit, valid or bad.
- Internal state: digit counter `cnt` (0..DIGITS-1), accumulator registers for nibbles, DP and bad bits, and separate output registers.
- Two states, COLLECT and HOLD:
  - COLLECT: `seg_ready`=1.
  - An input handshake (`seg_valid` and `seg_ready`) writes the decoded digit into accumulator slot `cnt` and increments `cnt`.
  - If `seg_first`=1 on a handshake, the byte goes into slot 0 and `cnt` becomes 1. Any partial frame is discarded and its slots are overwritten, with no error.
  - A handshake that fills slot DIGITS-1 copies the accumulator, including that digit, into the output registers. It sets `out_valid`, clears `seg_ready`, resets `cnt` to 0 and enters HOLD.
  - HOLD: `seg_ready`=0. On `out_valid` and `out_ready`, clear `out_valid`, set `seg_ready` and return to COLLECT.
- `seg_first` on slot DIGITS-1 with DIGITS=1: the frame completes normally.
- `hex_value`, `dp_mask` and `bad_mask` change only on the frame-completion edge. They hold the last frame otherwise, including during COLLECT.
- Bytes presented while `seg_ready`=0 are not consumed. The upstream source must hold them.

## Timing
- Reset values: `seg_ready`=0, `out_valid`=0, `hex_value`=0, `dp_mask`=0, `bad_mask`=0, `cnt`=0, state COLLECT.
- `seg_ready` rises on the first clock edge after `rst` deasserts.
- Latency: the last-digit handshake at edge N gives `out_valid`=1 and new outputs after edge N.
- Output handshake at edge M gives `seg_ready`=1 after M. The next byte can be accepted at edge M+1.
- Throughput: DIGITS+1 cycles per frame minimum, with a one-cycle bubble in HOLD.
- `out_ready` may be high before `out_valid`. The handshake then completes on the first edge `out_valid` is seen high.
- Reset asserted mid-frame or during HOLD: all state returns to reset values immediately (asynchronously). The partial or pending frame is lost.

## Test plan
- DIGITS=8, bytes 5E,79,77,5E,7C,79,79,71 (first on 5E), `out_ready`=1 -> `hex_value`=32'hDEADBEEF, `dp_mask`=00, `bad_mask`=00, `out_valid` one cycle after the 8th handshake.
- Digit 0 = BF, digits 1-7 = 3F -> `hex_value`=0, `dp_mask`=8'h80, `bad_mask`=00.
- Digit 3 = 00, digit 5 = 49, others 06 -> `hex_value`=32'h11101011, `bad_mask`=8'h14.
- Three digits sent, then `seg_first` with 8 new digits 06,5B,4F,66,6D,7D,07,7F -> exactly one frame, `hex_value`=32'h12345678.
- `out_ready` held low 5 cycles after `out_valid` -> `seg_ready`=0 and outputs stable throughout. `out_ready` high -> `out_valid` clears, `seg_ready`=1 next cycle.
- Assert `rst` after 4 digits -> all outputs 0. After release, a full frame of 3F decodes to 0 with no stale digits.

Source files
------------

// File: rtl/led7_frame_decoder.sv
// led7_frame_decoder: turns a stream of seven-segment bytes (one per digit,
// digit 0 first) back into a packed hex frame with per-digit DP and
// bad-glyph masks, and holds each completed frame on a valid/ready output.
//
// state   | meaning
// COLLECT | accepting bytes into the accumulator, seg_ready_o high
// HOLD    | completed frame presented, waiting for out_ready_i
module led7_frame_decoder #(
    parameter int DIGITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            seg_data_i,
    input  logic                  seg_first_i,
    input  logic                  seg_valid_i,
    output logic                  seg_ready_o,
    output logic [4*DIGITS-1:0]   hex_value_o,
    output logic [DIGITS-1:0]     dp_mask_o,
    output logic [DIGITS-1:0]     bad_mask_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   acc_hex_q, acc_hex_d;
    logic [DIGITS-1:0]     acc_dp_q, acc_dp_d;
    logic [DIGITS-1:0]     acc_bad_q, acc_bad_d;
    logic [4*DIGITS-1:0]   out_hex_q, out_hex_d;
    logic [DIGITS-1:0]     out_dp_q, out_dp_d;
    logic [DIGITS-1:0]     out_bad_q, out_bad_d;
    logic                  seg_ready_q, seg_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [CW-1:0]         slot;
    logic [CW-1:0]         pos;
    logic [4:0]            dec;

    // Returns {bad, nibble}; unknown patterns (blank included) give nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F: r = 5'h00;
            7'h06: r = 5'h01;
            7'h5B: r = 5'h02;
            7'h4F: r = 5'h03;
            7'h66: r = 5'h04;
            7'h6D: r = 5'h05;
            7'h7D: r = 5'h06;
            7'h07: r = 5'h07;
            7'h7F: r = 5'h08;
            7'h6F: r = 5'h09;
            7'h77: r = 5'h0A;
            7'h7C: r = 5'h0B;
            7'h39: r = 5'h0C;
            7'h5E: r = 5'h0D;
            7'h79: r = 5'h0E;
            7'h71: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // Register all state; reset is asynchronous.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            acc_hex_q   <= '0;
            acc_dp_q    <= '0;
            acc_bad_q   <= '0;
            out_hex_q   <= '0;
            out_dp_q    <= '0;
            out_bad_q   <= '0;
            seg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hex_q   <= acc_hex_d;
            acc_dp_q    <= acc_dp_d;
            acc_bad_q   <= acc_bad_d;
            out_hex_q   <= out_hex_d;
            out_dp_q    <= out_dp_d;
            out_bad_q   <= out_bad_d;
            seg_ready_q <= seg_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: decode and store the byte, complete the frame, drain HOLD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hex_d   = acc_hex_q;
        acc_dp_d    = acc_dp_q;
        acc_bad_d   = acc_bad_q;
        out_hex_d   = out_hex_q;
        out_dp_d    = out_dp_q;
        out_bad_d   = out_bad_q;
        seg_ready_d = seg_ready_q;
        out_valid_d = out_valid_q;

        // seg_first restarts the frame at slot 0, abandoning any partial one.
        slot = seg_first_i ? '0 : cnt_q;
        // Digit 0 lives in the most significant position.
        pos  = LAST - slot;
        dec  = decode_seg(seg_data_i[6:0]);

        case (state_q)
            COLLECT: begin
                seg_ready_d = 1'b1;
                if (seg_valid_i && seg_ready_q) begin
                    acc_hex_d[{pos, 2'b00} +: 4] = dec[3:0];
                    acc_dp_d[pos]                = seg_data_i[7];
                    acc_bad_d[pos]               = dec[4];
                    if (slot == LAST) begin
                        out_hex_d   = acc_hex_d;
                        out_dp_d    = acc_dp_d;
                        out_bad_d   = acc_bad_d;
                        out_valid_d = 1'b1;
                        seg_ready_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = slot + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    seg_ready_d = 1'b1;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign seg_ready_o = seg_ready_q;
    assign out_valid_o = out_valid_q;
    assign hex_value_o = out_hex_q;
    assign dp_mask_o   = out_dp_q;
    assign bad_mask_o  = out_bad_q;

endmodule

// File: tb/tb_led7_frame_decoder.sv
// Directed and randomized frames against a glyph-table lookup model.
module tb_led7_frame_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  seg_data_i = 8'h00;
    logic        seg_first_i = 1'b0;
    logic        seg_valid_i = 1'b0;
    logic        seg_ready_o;
    logic [31:0] hex_value_o;
    logic [7:0]  dp_mask_o;
    logic [7:0]  bad_mask_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    led7_frame_decoder #(.DIGITS(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .seg_data_i  (seg_data_i),
        .seg_first_i (seg_first_i),
        .seg_valid_i (seg_valid_i),
        .seg_ready_o (seg_ready_o),
        .hex_value_o (hex_value_o),
        .dp_mask_o   (dp_mask_o),
        .bad_mask_o  (bad_mask_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a byte's nibble is its index in the glyph table, else 0 and bad.
    task automatic model(input logic [7:0] b [8], output logic [31:0] h,
                         output logic [7:0] dp, output logic [7:0] bad);
        h = '0; dp = '0; bad = '0;
        for (int i = 0; i < 8; i++) begin
            bit found = 1'b0;
            logic [3:0] nib = 4'h0;
            for (int g = 0; g < 16; g++)
                if (glyph[g] == b[i][6:0]) begin
                    found = 1'b1;
                    nib   = 4'(g);
                end
            h[4*(7-i) +: 4] = nib;
            dp[7-i]         = b[i][7];
            bad[7-i]        = !found;
        end
    endtask

    // One handshake; returns #1 after the accepting edge.
    task automatic put(input logic [7:0] d, input logic f);
        int n = 0;
        @(negedge clk_i);
        seg_data_i  = d;
        seg_first_i = f;
        seg_valid_i = 1'b1;
        while (!seg_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("put_timeout", 64'(n < 50), 64'd1);
        @(posedge clk_i);
        #1;
        seg_valid_i = 1'b0;
        seg_first_i = 1'b0;
    endtask

    // Sends a whole frame, checks out_valid stays low until the last digit.
    task automatic send_frame(input logic [7:0] b [8], input logic first_on_0);
        for (int i = 0; i < 8; i++) begin
            put(b[i], (i == 0) ? first_on_0 : 1'b0);
            if (i < 7) chk("valid_early", 64'(out_valid_o), 64'd0);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b [8]);
        logic [31:0] h;
        logic [7:0]  dp, bad;
        model(b, h, dp, bad);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_ready"}, 64'(seg_ready_o), 64'd0);
        chk({tag, "_hex"},   64'(hex_value_o), 64'(h));
        chk({tag, "_dp"},    64'(dp_mask_o),   64'(dp));
        chk({tag, "_bad"},   64'(bad_mask_o),  64'(bad));
    endtask

    task automatic drain_check;
        @(posedge clk_i);
        #1;
        chk("drain_valid", 64'(out_valid_o), 64'd0);
        chk("drain_ready", 64'(seg_ready_o), 64'd1);
    endtask

    initial begin
        logic [7:0] fr [8];
        logic [31:0] held;

        // Reset values
        #1;
        chk("rst_ready", 64'(seg_ready_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_hex",   64'(hex_value_o), 64'd0);
        chk("rst_masks", 64'({dp_mask_o, bad_mask_o}), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("ready_pre_edge", 64'(seg_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("ready_post_edge", 64'(seg_ready_o), 64'd1);

        // DEADBEEF
        out_ready_i = 1'b1;
        fr = '{8'h5E, 8'h79, 8'h77, 8'h5E, 8'h7C, 8'h79, 8'h79, 8'h71};
        send_frame(fr, 1'b1);
        chk("deadbeef_hex", 64'(hex_value_o), 64'hDEADBEEF);
        check_frame("deadbeef", fr);
        drain_check();

        // DP on digit 0
        fr = '{8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        send_frame(fr, 1'b1);
        chk("dp_mask_const", 64'(dp_mask_o), 64'h80);
        check_frame("dp0", fr);
        drain_check();

        // Bad glyphs on digits 3 and 5
        fr = '{8'h06, 8'h06, 8'h06, 8'h00, 8'h06, 8'h49, 8'h06, 8'h06};
        send_frame(fr, 1'b1);
        chk("bad_hex_const", 64'(hex_value_o), 64'h11101011);
        chk("bad_mask_const", 64'(bad_mask_o), 64'h14);
        check_frame("bad", fr);
        drain_check();

        // Partial frame abandoned by seg_first
        put(8'h7F, 1'b1);
        put(8'h7F, 1'b0);
        put(8'h7F, 1'b0);
        chk("partial_no_valid", 64'(out_valid_o), 64'd0);
        fr = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
        send_frame(fr, 1'b1);
        chk("restart_hex_const", 64'(hex_value_o), 64'h12345678);
        check_frame("restart", fr);
        drain_check();
        repeat (3) begin
            @(posedge clk_i);
            #1;
            chk("one_frame_only", 64'(out_valid_o), 64'd0);
        end

        // Back-pressure: out_ready low for 5 cycles
        out_ready_i = 1'b0;
        fr = '{8'h39, 8'h5E, 8'hF9, 8'h71, 8'h3F, 8'h06, 8'h5B, 8'h4F};
        send_frame(fr, 1'b1);
        check_frame("stall", fr);
        held = hex_value_o;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_ready", 64'(seg_ready_o), 64'd0);
            chk("stall_hex", 64'(hex_value_o), 64'(held));
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        drain_check();

        // Held outputs stay put during COLLECT
        put(8'h06, 1'b1);
        put(8'h06, 1'b0);
        chk("hold_during_collect", 64'(hex_value_o), 64'(held));

        // Reset mid-frame, then a frame without seg_first starts at slot 0
        put(8'h7F, 1'b0);
        put(8'h7F, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("midrst_hex",   64'(hex_value_o), 64'd0);
        chk("midrst_masks", 64'({dp_mask_o, bad_mask_o}), 64'd0);
        chk("midrst_ready", 64'(seg_ready_o), 64'd0);
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        fr = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        send_frame(fr, 1'b0);
        chk("post_rst_hex", 64'(hex_value_o), 64'd0);
        check_frame("post_rst", fr);
        drain_check();

        // Randomized frames with random back-pressure and idle gaps
        for (int f = 0; f < 25; f++) begin
            int stall;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(9) < 7)
                    fr[i] = {1'($urandom_range(1)), glyph[$urandom_range(15)]};
                else
                    fr[i] = 8'($urandom);
            end
            stall = $urandom_range(3);
            out_ready_i = (stall == 0);
            repeat ($urandom_range(2)) @(negedge clk_i);
            send_frame(fr, 1'($urandom_range(1)));
            check_frame("rand", fr);
            if (stall != 0) begin
                repeat (stall) @(negedge clk_i);
                chk("rand_stall_valid", 64'(out_valid_o), 64'd1);
                out_ready_i = 1'b1;
            end
            drain_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
